sr_operand_stage: RTL and testbench
===================================

Name: sr_operand_stage

Overview:
- Operand-fetch/issue stage that sits directly upstream of sr_alu and drives its srcA, srcB and oper inputs from a registered output slot.
- Contains the 32x32 register file (x0 hardwired to zero), the write-back bypass and a per-register pending scoreboard.
- Uses a valid/ready handshake on both sides, so an instruction is issued only when its operands are final.

Parameters:
- NREGS, 32, number of architectural registers; must be a power of 2.
- XLEN, 32, data width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts instruction this cycle
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_imm  in  XLEN  immediate
- in_use_imm  in  1  1: srcB = in_imm, and rs2 is ignored
- in_oper  in  3  ALU opcode, passed through unchanged
- in_rd  in  5  destination register
- in_rd_we  in  1  instruction writes rd
- out_valid  out  1  output slot holds an issued instruction
- out_ready  in  1  ALU/EX stage consumes the slot
- out_srcA  out  XLEN  operand A to ALU
- out_srcB  out  XLEN  operand B to ALU
- out_oper  out  3  opcode to ALU
- out_rd  out  5  destination register
- out_rd_we  out  1  write enable for rd
- wb_we  in  1  write-back strobe
- wb_addr  in  5  write-back register
- wb_data  in  XLEN  write-back data
- flush  in  1  synchronous kill of the output slot

Behaviour:
- Reset (rst_n low, asynchronous): all registers 0, pending bits 0, out_valid 0, all out_* data fields 0. Reset mid-operation discards the held slot and all pending state.
- Register file write: on wb_we && wb_addr != 0, regs[wb_addr] <= wb_data at the clock edge.
  - Reads of x0 always return 0.
  - Writes to x0 are ignored.
- Bypass: if wb_we && wb_addr == rsX && rsX != 0, the operand read uses wb_data in the same cycle (write-first).
- Pending scoreboard, one bit per register (x0 bit tied to 0):
  - Set pending[in_rd] on accept (in_valid && in_ready) when in_rd_we && in_rd != 0.
  - Clear pending[wb_addr] on wb_we.
  - If a set and a clear hit the same register in the same cycle, set wins.
- Hazard: hz = (pend_eff[in_rs1]) || (!in_use_imm && pend_eff[in_rs2]) || (in_rd_we && pend_eff[in_rd]), where pend_eff = pending with the current cycle's wb clear already applied.
  - RAW is resolved through the bypass.
  - WAW stalls the incoming instruction.
- in_ready = !hz && (!out_valid || out_ready) && !flush. It is combinational and does not depend on in_valid.
- Slot update, evaluated in priority order:
  1. flush: out_valid <= 0. If the slot held out_rd_we && out_rd != 0 and that entry is not being consumed this cycle, clear pending[out_rd]. No accept occurs this cycle.
  2. accept: capture srcA, srcB (rs2 value or in_imm), oper, rd and rd_we; out_valid <= 1.
  3. out_ready && out_valid without an accept: out_valid <= 0.
  4. Otherwise hold. Outputs stay stable while out_valid && !out_ready.
- Latency: 1 cycle from accept to out_valid. Throughput is one instruction per cycle when there are no hazards.
- Width rules: srcB mux is XLEN bits; in_oper is not interpreted.

Decomposition:
- Shared package/header sr_cpu:
  - ALU opcode constants (ALU_ADD, ALU_OR, ALU_SRL, ALU_SLTU, ALU_SUB, ALU_MUL).
  - Register-index width of 5.
  - A struct for the issued slot (srcA, srcB, oper, rd, rd_we).
- Sub-module sr_regfile_2r1w: 2 combinational read ports, 1 write port, x0 = 0, asynchronous active-low reset, write-first bypass.
- Scoreboard and output slot stay in the top module.

Test Plan:
- Reset then idle: out_valid=0, all outputs 0, in_ready=1; a read of x5 yields 0.
- wb x3=0x1234 in cycle N; in cycle N issue ADD rs1=x3 rs2=x0 -> out_srcA=0x1234 (bypass), out_srcB=0 in cycle N+1.
- Issue rd=x7 (slot consumed), then issue rs1=x7 -> in_ready=0 until wb x7=0xAB. In the wb cycle in_ready=1 and out_srcA=0xAB on the next cycle.
- Hold out_ready=0 with a held slot (srcA=5) while new instructions are presented -> outputs stable and in_ready=0. Raise out_ready -> the next instruction is accepted the same cycle.
- Slot holds rd=x9 pending; assert flush -> out_valid=0 next cycle, pending[x9]=0, and a following rs1=x9 issue is not stalled.
- Write x0 with 0xFFFF then issue rs1=x0 -> srcA=0. Assert rst_n low mid-stall -> out_valid=0 immediately and pending cleared.

Source files
------------

// File: rtl/sr_cpu_pkg.sv
// Shared definitions for the sr_cpu pipeline:
// ALU opcodes, register index width and the issued-slot bundle.
package sr_cpu_pkg;

  localparam int RIDX_W = 5;
  localparam int XLEN_P = 32;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_OR   = 3'd1;
  localparam logic [2:0] ALU_SRL  = 3'd2;
  localparam logic [2:0] ALU_SLTU = 3'd3;
  localparam logic [2:0] ALU_SUB  = 3'd4;
  localparam logic [2:0] ALU_MUL  = 3'd5;

  typedef struct packed {
    logic [XLEN_P-1:0] srca;
    logic [XLEN_P-1:0] srcb;
    logic [2:0]        oper;
    logic [RIDX_W-1:0] rd;
    logic              rd_we;
  } slot_t;

endpackage

// File: rtl/sr_regfile_2r1w.sv
// Two-read one-write register file, x0 reads as zero,
// write-first bypass on both read ports.
module sr_regfile_2r1w
  import sr_cpu_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int XLEN  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RIDX_W-1:0] ra1,
  input  logic [RIDX_W-1:0] ra2,
  output logic [XLEN-1:0]   rd1,
  output logic [XLEN-1:0]   rd2,
  input  logic              we,
  input  logic [RIDX_W-1:0] wa,
  input  logic [XLEN-1:0]   wd
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa[AW-1:0]] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 :
               (we && wa == ra1) ? wd : regs[ra1[AW-1:0]];
  assign rd2 = (ra2 == '0) ? '0 :
               (we && wa == ra2) ? wd : regs[ra2[AW-1:0]];

endmodule

// File: rtl/sr_operand_stage.sv
// Operand fetch/issue stage: regfile, pending scoreboard
// and a registered issue slot feeding the ALU.
module sr_operand_stage
  import sr_cpu_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int XLEN  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [RIDX_W-1:0] in_rs1,
  input  logic [RIDX_W-1:0] in_rs2,
  input  logic [XLEN-1:0]   in_imm,
  input  logic              in_use_imm,
  input  logic [2:0]        in_oper,
  input  logic [RIDX_W-1:0] in_rd,
  input  logic              in_rd_we,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_srcA,
  output logic [XLEN-1:0]   out_srcB,
  output logic [2:0]        out_oper,
  output logic [RIDX_W-1:0] out_rd,
  output logic              out_rd_we,
  input  logic              wb_we,
  input  logic [RIDX_W-1:0] wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush
);

  localparam int AW = $clog2(NREGS);

  if (XLEN != XLEN_P) begin : g_bad_xlen
    $error("XLEN must match the slot bundle width");
  end
  if ((1 << AW) != NREGS) begin : g_bad_nregs
    $error("NREGS must be a power of 2");
  end

  logic [XLEN-1:0]  rs1_val;
  logic [XLEN-1:0]  rs2_val;
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pend_eff;
  logic [NREGS-1:0] wb_clr;
  logic [NREGS-1:0] pend_nxt;
  logic             hz;
  logic             accept;
  logic             consume;
  slot_t            slot;

  sr_regfile_2r1w #(
    .NREGS(NREGS),
    .XLEN (XLEN)
  ) u_rf (
    .clk  (clk),
    .rst_n(rst_n),
    .ra1  (in_rs1),
    .ra2  (in_rs2),
    .rd1  (rs1_val),
    .rd2  (rs2_val),
    .we   (wb_we),
    .wa   (wb_addr),
    .wd   (wb_data)
  );

  always_comb begin
    wb_clr = '0;
    if (wb_we) wb_clr[wb_addr[AW-1:0]] = 1'b1;
  end

  // Same-cycle write-back already counts as resolved (bypass)
  assign pend_eff = pending & ~wb_clr;

  assign hz = pend_eff[in_rs1[AW-1:0]]
            | (!in_use_imm & pend_eff[in_rs2[AW-1:0]])
            | (in_rd_we & pend_eff[in_rd[AW-1:0]]);

  assign consume  = out_valid & out_ready;
  assign in_ready = !hz && (!out_valid || out_ready) && !flush;
  assign accept   = in_valid & in_ready;

  always_comb begin
    pend_nxt = pend_eff;
    // A killed, unconsumed slot will never write back
    if (flush && out_valid && !out_ready
        && slot.rd_we && slot.rd != '0)
      pend_nxt[slot.rd[AW-1:0]] = 1'b0;
    if (accept && in_rd_we && in_rd != '0)
      pend_nxt[in_rd[AW-1:0]] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pend_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      slot      <= '0;
    end else begin
      unique case (1'b1)
        flush: begin
          out_valid <= 1'b0;
        end
        accept: begin
          out_valid  <= 1'b1;
          slot.srca  <= rs1_val;
          slot.srcb  <= in_use_imm ? in_imm : rs2_val;
          slot.oper  <= in_oper;
          slot.rd    <= in_rd;
          slot.rd_we <= in_rd_we;
        end
        (consume && !accept && !flush): begin
          out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign out_srcA  = slot.srca;
  assign out_srcB  = slot.srcb;
  assign out_oper  = slot.oper;
  assign out_rd    = slot.rd;
  assign out_rd_we = slot.rd_we;

endmodule

// File: tb/tb_sr_operand_stage.sv
// Bench for sr_operand_stage: vector table with in_ready
// expectations plus a queue scoreboard of issued slots.
module tb_sr_operand_stage;
  import sr_cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_imm;
  logic        in_use_imm;
  logic [2:0]  in_oper;
  logic        in_rd_we;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_srcA, out_srcB;
  logic [2:0]  out_oper;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;

  sr_operand_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .in_use_imm(in_use_imm),
    .in_oper   (in_oper),
    .in_rd     (in_rd),
    .in_rd_we  (in_rd_we),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_srcA  (out_srcA),
    .out_srcB  (out_srcB),
    .out_oper  (out_oper),
    .out_rd    (out_rd),
    .out_rd_we (out_rd_we),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .flush     (flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  rs1, rs2;
    logic        ui;
    logic [31:0] imm;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic        we;
    logic        wbwe;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic        ordy;
    logic        fl;
    logic        er;
  } vec_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  int checks = 0;
  int errors = 0;
  logic [31:0] mreg [32];
  exp_t sbq[$];
  exp_t snap;
  logic held_prev = 1'b0;
  vec_t tbl[$];

  function automatic vec_t mk(
    logic v, logic [4:0] rs1, logic [4:0] rs2, logic ui,
    logic [31:0] imm, logic [2:0] op, logic [4:0] rd,
    logic we, logic wbwe, logic [4:0] wba, logic [31:0] wbd,
    logic ordy, logic fl, logic er);
    vec_t t;
    t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.ui = ui;
    t.imm = imm; t.op = op; t.rd = rd; t.we = we;
    t.wbwe = wbwe; t.wba = wba; t.wbd = wbd;
    t.ordy = ordy; t.fl = fl; t.er = er;
    return t;
  endfunction

  function automatic logic [31:0] mval(logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (wb_we && wb_addr == r) return wb_data;
    return mreg[r];
  endfunction

  function automatic exp_t cur_out();
    exp_t e;
    e.a = out_srcA; e.b = out_srcB; e.op = out_oper;
    e.rd = out_rd; e.we = out_rd_we;
    return e;
  endfunction

  task automatic chk(string name, logic [72:0] act,
                     logic [72:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus from negedge to next negedge
  task automatic tick(vec_t t, string name);
    exp_t e;
    in_valid = t.v; in_rs1 = t.rs1; in_rs2 = t.rs2;
    in_use_imm = t.ui; in_imm = t.imm; in_oper = t.op;
    in_rd = t.rd; in_rd_we = t.we;
    wb_we = t.wbwe; wb_addr = t.wba; wb_data = t.wbd;
    out_ready = t.ordy; flush = t.fl;
    #1;
    chk({name, ".in_ready"}, 73'(in_ready), 73'(t.er));
    if (held_prev) chk({name, ".stable"}, cur_out(), snap);
    held_prev = out_valid && !out_ready && !flush;
    snap = cur_out();
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s.unexpected_out got %h", name, cur_out());
      end else begin
        chk({name, ".slot"}, cur_out(), sbq.pop_front());
      end
    end
    if (in_valid && in_ready) begin
      e.a = mval(in_rs1);
      e.b = in_use_imm ? in_imm : mval(in_rs2);
      e.op = in_oper; e.rd = in_rd; e.we = in_rd_we;
      sbq.push_back(e);
    end
    @(posedge clk);
    if (t.wbwe && t.wba != 5'd0) mreg[t.wba] = t.wbd;
    if (t.fl) sbq.delete();
    @(negedge clk);
  endtask

  function automatic vec_t idle();
    return mk(0,0,0,0,0,0,0,0, 0,0,0, 1,0, 1);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    rst_n = 1'b0;
    in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_imm = 0;
    in_use_imm = 0; in_oper = 0; in_rd = 0; in_rd_we = 0;
    out_ready = 1; wb_we = 0; wb_addr = 0; wb_data = 0;
    flush = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.out_valid", 73'(out_valid), 73'd0);
    chk("rst.slot", cur_out(), '0);
    chk("rst.in_ready", 73'(in_ready), 73'd1);

    tbl.push_back(mk(1,5,5,0,0,ALU_ADD,0,0, 0,0,0, 1,0,1));
    tbl.push_back(mk(1,3,0,0,0,ALU_ADD,0,0, 1,3,32'h1234, 1,0,1));
    tbl.push_back(mk(1,3,0,1,32'h55,ALU_OR,7,1, 0,0,0, 1,0,1));
    tbl.push_back(mk(1,7,0,0,0,ALU_SUB,1,1, 0,0,0, 1,0,0));
    tbl.push_back(mk(1,7,0,0,0,ALU_SUB,1,1, 0,0,0, 1,0,0));
    tbl.push_back(mk(1,7,0,0,0,ALU_SUB,1,1, 1,7,32'hAB, 1,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,1,32'h10, 1,0,1));
    tbl.push_back(mk(1,0,0,0,0,ALU_ADD,2,1, 0,0,0, 1,0,1));
    tbl.push_back(mk(1,0,0,0,0,ALU_ADD,2,1, 0,0,0, 1,0,0));
    tbl.push_back(mk(1,0,0,0,0,ALU_ADD,2,1, 1,2,32'h22, 1,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,2,32'h33, 1,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,4,32'h5, 1,0,1));
    tbl.push_back(mk(1,4,2,0,0,ALU_MUL,0,0, 0,0,0, 0,0,1));
    tbl.push_back(mk(1,1,2,0,0,ALU_SLTU,0,0, 0,0,0, 0,0,0));
    tbl.push_back(mk(1,1,2,0,0,ALU_SLTU,0,0, 0,0,0, 0,0,0));
    tbl.push_back(mk(1,1,2,0,0,ALU_SLTU,0,0, 0,0,0, 1,0,1));
    tbl.push_back(idle());
    for (int i = 0; i < tbl.size(); i++)
      tick(tbl[i], $sformatf("v%0d", i));

    // Flush a held slot whose rd is pending
    tick(mk(1,0,0,0,0,ALU_ADD,9,1, 0,0,0, 1,0,1), "f1");
    tick(mk(0,0,0,0,0,0,0,0, 0,0,0, 0,1,0), "f2");
    chk("f2.out_valid", 73'(out_valid), 73'd0);
    tick(mk(1,9,0,0,0,ALU_ADD,0,0, 0,0,0, 1,0,1), "f3");
    tick(idle(), "f4");

    // x0 write ignored, then reset during a stall
    tick(mk(1,0,0,0,0,ALU_ADD,0,0, 1,0,32'hFFFF, 1,0,1), "z1");
    tick(mk(1,0,0,0,0,ALU_ADD,6,1, 0,0,0, 1,0,1), "z2");
    tick(mk(1,6,0,0,0,ALU_ADD,0,0, 0,0,0, 0,0,0), "z3");
    #2 rst_n = 1'b0;
    #1;
    chk("rst2.out_valid", 73'(out_valid), 73'd0);
    chk("rst2.in_ready", 73'(in_ready), 73'd1);
    sbq.delete();
    held_prev = 1'b0;
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(mk(1,6,1,0,0,ALU_ADD,0,0, 0,0,0, 1,0,1), "z4");
    tick(idle(), "z5");
    tick(idle(), "z6");
    chk("drain.queue", 73'(sbq.size()), 73'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
